// File: rtl/noc_params.sv
// Shared NoC parameters and flit types, including the depacketizer FSM state and depth default.
package noc_params;

  localparam int VC_NUM          = 2;
  localparam int VC_SIZE         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PAYLOAD_W       = 16;
  localparam int DEPKT_BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t            flit_label;
    logic [VC_SIZE-1:0]     vc_id;
    logic [PAYLOAD_W-1:0]   data;
  } flit_t;

  typedef struct packed {
    flit_label_t            flit_label;
    logic [PAYLOAD_W-1:0]   data;
  } flit_novc_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } depkt_state_t;

  // Successor VC, wrapping modulo VC_NUM even when VC_NUM is not a power of two.
  function automatic logic [VC_SIZE-1:0] next_vc(input logic [VC_SIZE-1:0] v);
    if (int'(v) == VC_NUM - 1) next_vc = '0;
    else                       next_vc = v + 1'b1;
  endfunction

endpackage

// File: rtl/depkt_vc_fifo.sv
// Per-VC first-word-fall-through flit FIFO; head is valid the cycle after the first push.
// Pushes while full are dropped; pops while empty are ignored.
module depkt_vc_fifo
  import noc_params::*;
#(
  parameter int BUF_DEPTH = DEPKT_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  flit_novc_t                 i_din,
  input  logic                       i_pop,
  output flit_novc_t                 o_head,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(BUF_DEPTH):0] o_count
);

  localparam int AW = $clog2(BUF_DEPTH);

  flit_novc_t    r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(BUF_DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/noc_depacketizer.sv
// Local-port ejection: per-VC FIFOs, round-robin packet-at-a-time drain, on/off and allocatable status.
// Optional DEPKT_CHECK_EN adds per-VC framing checks that drop bad flits and pulse err_o.
module noc_depacketizer
  import noc_params::*;
#(
  parameter int BUF_DEPTH = DEPKT_BUF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  flit_t              flit_i,
  input  logic               valid_i,
  output logic [VC_NUM-1:0]  on_off_o,
  output logic [VC_NUM-1:0]  is_allocatable_o,
  output flit_novc_t         out_flit_o,
  output logic [VC_SIZE-1:0] out_vc_o,
  output logic               out_sop_o,
  output logic               out_eop_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               err_o
);

  localparam int              CW       = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0]   ON_LIMIT = CW'(BUF_DEPTH - 1);

  flit_novc_t         w_wr_flit;
  logic               w_is_head_in;
  logic               w_wr_ok;
  logic [VC_NUM-1:0]  w_push;
  logic [VC_NUM-1:0]  w_pop;
  logic [VC_NUM-1:0]  w_empty;
  logic [VC_NUM-1:0]  w_full;
  logic [VC_NUM-1:0]  w_cand;
  flit_novc_t         w_head  [VC_NUM];
  logic [CW-1:0]      w_count [VC_NUM];

  depkt_state_t       r_state;
  depkt_state_t       w_state_nxt;
  logic [VC_SIZE-1:0] r_rr_ptr;
  logic [VC_SIZE-1:0] w_rr_nxt;
  logic [VC_SIZE-1:0] r_lock_vc;
  logic [VC_SIZE-1:0] w_lock_nxt;
  logic [VC_SIZE-1:0] w_grant;
  logic [VC_SIZE-1:0] w_idx;
  logic [VC_SIZE-1:0] w_sel_vc;
  logic               w_found;
  logic               w_vld;
  logic               w_fire;
  flit_novc_t         w_sel_flit;
  logic [VC_NUM-1:0]  r_alloc;

  assign w_wr_flit    = '{flit_label: flit_i.flit_label, data: flit_i.data};
  assign w_is_head_in = (flit_i.flit_label == HEAD) || (flit_i.flit_label == HEADTAIL);

`ifdef DEPKT_CHECK_EN
  logic [VC_NUM-1:0] r_open;
  logic              r_err;
  logic              w_err;

  // A head is legal only on a closed VC and a body/tail only on an open one.
  always_comb begin
    w_err = 1'b0;
    if (valid_i) begin
      if (w_full[flit_i.vc_id])                      w_err = 1'b1;
      else if (w_is_head_in == r_open[flit_i.vc_id]) w_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err;
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_push[v]) begin
          if (flit_i.flit_label == HEAD)      r_open[v] <= 1'b1;
          else if (flit_i.flit_label == TAIL) r_open[v] <= 1'b0;
        end
      end
    end
  end

  assign w_wr_ok = !w_err;
  assign err_o   = r_err;
`else
  assign w_wr_ok = 1'b1;
  assign err_o   = 1'b0;
`endif

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_push[v]   = valid_i && w_wr_ok && (flit_i.vc_id == VC_SIZE'(v));
    assign w_cand[v]   = !w_empty[v] &&
                         ((w_head[v].flit_label == HEAD) || (w_head[v].flit_label == HEADTAIL));
    assign on_off_o[v] = (w_count[v] < ON_LIMIT);

    depkt_vc_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[v]),
      .i_din   (w_wr_flit),
      .i_pop   (w_pop[v]),
      .o_head  (w_head[v]),
      .o_empty (w_empty[v]),
      .o_full  (w_full[v]),
      .o_count (w_count[v])
    );
  end

  // Round-robin search for a VC whose FIFO head starts a packet.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      w_idx = VC_SIZE'((int'(r_rr_ptr) + i) % VC_NUM);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_vc;
    w_sel_vc    = '0;
    w_vld       = 1'b0;
    w_pop       = '0;
    case (r_state)
      IDLE: begin
        w_sel_vc = w_grant;
        w_vld    = w_found;
      end
      STREAM: begin
        w_sel_vc = r_lock_vc;
        w_vld    = !w_empty[r_lock_vc];
      end
      default: ;
    endcase
    w_sel_flit = w_head[w_sel_vc];
    out_sop_o  = w_vld && ((w_sel_flit.flit_label == HEAD) || (w_sel_flit.flit_label == HEADTAIL));
    out_eop_o  = w_vld && ((w_sel_flit.flit_label == TAIL) || (w_sel_flit.flit_label == HEADTAIL));
    w_fire     = w_vld && out_ready_i;
    if (w_fire) begin
      w_pop[w_sel_vc] = 1'b1;
      if (out_eop_o) begin
        w_state_nxt = IDLE;
        w_rr_nxt    = next_vc(w_sel_vc);
      end else if (r_state == IDLE) begin
        w_state_nxt = STREAM;
        w_lock_nxt  = w_sel_vc;
      end
    end
  end

  assign out_valid_o      = w_vld;
  assign out_flit_o       = w_sel_flit;
  assign out_vc_o         = w_sel_vc;
  assign is_allocatable_o = r_alloc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_lock_vc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_vc <= w_lock_nxt;
    end
  end

  // A new packet arriving wins over the previous one leaving on the same VC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc <= '1;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_push[v] && !w_full[v] && w_is_head_in) r_alloc[v] <= 1'b0;
        else if (w_pop[v] && out_eop_o)              r_alloc[v] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_depacketizer.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_noc_depacketizer;
  import noc_params::*;

  localparam int DEPTH = DEPKT_BUF_DEPTH;

  logic               clk = 1'b0;
  logic               rst_n;
  flit_t              flit_i;
  logic               valid_i;
  logic [VC_NUM-1:0]  on_off_o;
  logic [VC_NUM-1:0]  is_allocatable_o;
  flit_novc_t         out_flit_o;
  logic [VC_SIZE-1:0] out_vc_o;
  logic               out_sop_o;
  logic               out_eop_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic               err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_depacketizer #(.BUF_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flit_i           (flit_i),
    .valid_i          (valid_i),
    .on_off_o         (on_off_o),
    .is_allocatable_o (is_allocatable_o),
    .out_flit_o       (out_flit_o),
    .out_vc_o         (out_vc_o),
    .out_sop_o        (out_sop_o),
    .out_eop_o        (out_eop_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .err_o            (err_o)
  );

  task automatic drive(input flit_label_t l, input logic [VC_SIZE-1:0] vc, input logic [PAYLOAD_W-1:0] d);
    valid_i = 1'b1;
    flit_i  = '{flit_label: l, vc_id: vc, data: d};
  endtask

  task automatic idle_in();
    valid_i = 1'b0;
    flit_i  = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_in();
    out_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    out_ready_i = 1'b0;
    #13;
    checks++;
    if ({out_valid_o, out_sop_o, out_eop_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got %b expected 000", {out_valid_o, out_sop_o, out_eop_o});
    end
    checks++;
    if (out_vc_o !== '0) begin errors++; $display("FAIL reset_vc got %h expected 0", out_vc_o); end
    checks++;
    if (on_off_o !== {VC_NUM{1'b1}}) begin errors++; $display("FAIL reset_on_off got %b", on_off_o); end
    checks++;
    if (is_allocatable_o !== {VC_NUM{1'b1}}) begin errors++; $display("FAIL reset_alloc got %b", is_allocatable_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_headtail();
    @(negedge clk);
    out_ready_i = 1'b1;
    drive(HEADTAIL, 1'b1, 16'h002A);
    checks++;
    if (is_allocatable_o !== 2'b11) begin errors++; $display("FAIL ht_alloc_pre got %b expected 11", is_allocatable_o); end
    @(negedge clk);
    idle_in();
    checks++;
    if ({out_valid_o, out_sop_o, out_eop_o, out_vc_o} !== 4'b1111) begin
      errors++; $display("FAIL ht_ctl got %b expected 1111", {out_valid_o, out_sop_o, out_eop_o, out_vc_o});
    end
    checks++;
    if (out_flit_o !== '{flit_label: HEADTAIL, data: 16'h002A}) begin
      errors++; $display("FAIL ht_flit got %h expected %h", out_flit_o, {HEADTAIL, 16'h002A});
    end
    checks++;
    if (is_allocatable_o !== 2'b01) begin errors++; $display("FAIL ht_alloc_mid got %b expected 01", is_allocatable_o); end
    @(negedge clk);
    checks++;
    if ({out_valid_o, is_allocatable_o} !== 3'b011) begin
      errors++; $display("FAIL ht_after got %b expected 011", {out_valid_o, is_allocatable_o});
    end
  endtask

  task automatic test_four_flit();
    flit_label_t lbl [4];
    lbl = '{HEAD, BODY, BODY, TAIL};
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (is_allocatable_o !== 2'b10) begin errors++; $display("FAIL pkt4_alloc got %b expected 10", is_allocatable_o); end
      end
      if (i == 2) begin
        checks++;
        if (on_off_o[0] !== 1'b1) begin errors++; $display("FAIL pkt4_on_off2 got %b expected 1", on_off_o[0]); end
      end
      if (i == 3) begin
        checks++;
        if (on_off_o[0] !== 1'b0) begin errors++; $display("FAIL pkt4_on_off3 got %b expected 0", on_off_o[0]); end
      end
      drive(lbl[i], 1'b0, PAYLOAD_W'(16'h0100 + i));
    end
    @(negedge clk);
    idle_in();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid_o, out_sop_o, out_eop_o, out_vc_o} !== {1'b1, (i == 0), (i == 3), 1'b0}) begin
        errors++; $display("FAIL pkt4_ctl%0d got %b expected %b", i,
          {out_valid_o, out_sop_o, out_eop_o, out_vc_o}, {1'b1, (i == 0), (i == 3), 1'b0});
      end
      checks++;
      if (out_flit_o.data !== PAYLOAD_W'(16'h0100 + i)) begin
        errors++; $display("FAIL pkt4_data%0d got %h expected %h", i, out_flit_o.data, 16'h0100 + i);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid_o, on_off_o, is_allocatable_o} !== 5'b01111) begin
      errors++; $display("FAIL pkt4_end got %b expected 01111", {out_valid_o, on_off_o, is_allocatable_o});
    end
  endtask

  task automatic test_no_interleave();
    flit_t      stim [4];
    flit_t      exp  [4];
    flit_t      obs  [$];
    stim = '{'{HEAD, 1'b0, 16'h10}, '{HEADTAIL, 1'b1, 16'h20}, '{BODY, 1'b0, 16'h11}, '{TAIL, 1'b0, 16'h12}};
    exp  = '{'{HEAD, 1'b0, 16'h10}, '{BODY, 1'b0, 16'h11}, '{TAIL, 1'b0, 16'h12}, '{HEADTAIL, 1'b1, 16'h20}};
    out_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid_o && out_ready_i)
        obs.push_back('{flit_label: out_flit_o.flit_label, vc_id: out_vc_o, data: out_flit_o.data});
      if (c < 4) drive(stim[c].flit_label, stim[c].vc_id, stim[c].data);
      else       idle_in();
    end
    checks++;
    if (obs.size() != 4) begin
      errors++; $display("FAIL ilv_count got %0d expected 4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs[i] !== exp[i]) begin errors++; $display("FAIL ilv_order%0d got %h expected %h", i, obs[i], exp[i]); end
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [PAYLOAD_W-1:0] d [4];
    int                   nobs;
    out_ready_i = 1'b0;
    nobs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d[i] = PAYLOAD_W'($urandom);
      drive(HEADTAIL, VC_SIZE'(i % 2), d[i]);
    end
    @(negedge clk);
    idle_in();
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_o) begin
        if (nobs < 4) begin
          checks++;
          if ({out_vc_o, out_flit_o.data} !== {VC_SIZE'(nobs % 2), d[nobs]}) begin
            errors++; $display("FAIL rr_grant%0d got vc %0d data %h expected vc %0d data %h",
              nobs, out_vc_o, out_flit_o.data, nobs % 2, d[nobs]);
          end
        end
        nobs++;
      end
      @(negedge clk);
    end
    checks++;
    if (nobs != 4) begin errors++; $display("FAIL rr_count got %0d expected 4", nobs); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready_i = 1'b0;
    @(negedge clk); drive(HEAD, 1'b0, 16'hAAAA);
    @(negedge clk); drive(BODY, 1'b0, 16'hBBBB);
    @(negedge clk); idle_in();
    checks++;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rstm_pre got %b expected 1", out_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_sop_o, out_eop_o, out_vc_o, err_o} !== 5'b0) begin
      errors++; $display("FAIL rstm_ctl got %b expected 00000", {out_valid_o, out_sop_o, out_eop_o, out_vc_o, err_o});
    end
    checks++;
    if ({on_off_o, is_allocatable_o} !== 4'b1111) begin
      errors++; $display("FAIL rstm_status got %b expected 1111", {on_off_o, is_allocatable_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    drive(HEADTAIL, 1'b0, 16'h0055);
    @(negedge clk);
    idle_in();
    checks++;
    if ({out_valid_o, out_sop_o, out_eop_o, out_vc_o, out_flit_o.data} !== {4'b1110, 16'h0055}) begin
      errors++; $display("FAIL rstm_new got %b_%h expected 1110_0055",
        {out_valid_o, out_sop_o, out_eop_o, out_vc_o}, out_flit_o.data);
    end
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rstm_stale got %b expected 0", out_valid_o); end
  endtask

  task automatic test_error_checker();
    out_ready_i = 1'b1;
    @(negedge clk);
    drive(BODY, 1'b1, 16'h0077);
    @(negedge clk);
    idle_in();
`ifdef DEPKT_CHECK_EN
    checks++;
    if ({err_o, out_valid_o} !== 2'b10) begin errors++; $display("FAIL err_pulse got %b expected 10", {err_o, out_valid_o}); end
    @(negedge clk);
    checks++;
    if ({err_o, out_valid_o} !== 2'b00) begin errors++; $display("FAIL err_clear got %b expected 00", {err_o, out_valid_o}); end
    drive(HEADTAIL, 1'b1, 16'h0078);
    @(negedge clk);
    idle_in();
    checks++;
    if ({out_valid_o, out_sop_o, out_vc_o, out_flit_o.data} !== {3'b111, 16'h0078}) begin
      errors++; $display("FAIL err_dropped got %b_%h expected 111_0078", {out_valid_o, out_sop_o, out_vc_o}, out_flit_o.data);
    end
`else
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({err_o, out_valid_o} !== 2'b00) begin errors++; $display("FAIL err_off%0d got %b expected 00", c, {err_o, out_valid_o}); end
      @(negedge clk);
    end
`endif
    apply_reset();
  endtask

  task automatic test_random();
    flit_novc_t           mq [VC_NUM][$];
    logic [VC_NUM-1:0]    m_alloc;
    int                   rem [VC_NUM];
    bit                   in_pkt;
    int                   pkt_vc;
    bit                   drain;
    bit                   rdy, do_pop, pop_end, do_push, full_pre;
    int                   pop_vc, push_vc, len;
    flit_novc_t           pf, expf;
    int                   total;
    m_alloc = '1;
    in_pkt  = 0;
    pkt_vc  = 0;
    for (int v = 0; v < VC_NUM; v++) rem[v] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      drain = (cyc >= 2500);
      total = 0;
      for (int v = 0; v < VC_NUM; v++) total += mq[v].size() + rem[v];
      if (drain && total == 0) break;
      for (int v = 0; v < VC_NUM; v++) begin
        checks++;
        if (on_off_o[v] !== (mq[v].size() < DEPTH - 1)) begin
          errors++; $display("FAIL rnd_on_off vc%0d cyc %0d got %b model count %0d", v, cyc, on_off_o[v], mq[v].size());
        end
      end
      checks++;
      if ({is_allocatable_o, err_o} !== {m_alloc, 1'b0}) begin
        errors++; $display("FAIL rnd_alloc cyc %0d got %b expected %b", cyc, {is_allocatable_o, err_o}, {m_alloc, 1'b0});
      end
      rdy = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
      do_pop = 0; pop_end = 0; pop_vc = 0;
      if (out_valid_o && rdy) begin
        pop_vc = int'(out_vc_o);
        checks++;
        if (mq[pop_vc].size() == 0) begin
          errors++; $display("FAIL rnd_spurious cyc %0d vc %0d got flit %h expected none", cyc, pop_vc, out_flit_o);
        end else begin
          expf = mq[pop_vc][0];
          if (out_flit_o !== expf) begin
            errors++; $display("FAIL rnd_flit cyc %0d vc %0d got %h expected %h", cyc, pop_vc, out_flit_o, expf);
          end
          checks++;
          if ({out_sop_o, out_eop_o} !== {(expf.flit_label == HEAD) || (expf.flit_label == HEADTAIL),
                                           (expf.flit_label == TAIL) || (expf.flit_label == HEADTAIL)}) begin
            errors++; $display("FAIL rnd_sopeop cyc %0d got %b for label %0d", cyc, {out_sop_o, out_eop_o}, expf.flit_label);
          end
          if (in_pkt) begin
            checks++;
            if (pop_vc != pkt_vc) begin
              errors++; $display("FAIL rnd_interleave cyc %0d got vc %0d expected vc %0d", cyc, pop_vc, pkt_vc);
            end
          end
          if (expf.flit_label == HEAD) begin in_pkt = 1; pkt_vc = pop_vc; end
          if (expf.flit_label == TAIL) in_pkt = 0;
          do_pop  = 1;
          pop_end = (expf.flit_label == TAIL) || (expf.flit_label == HEADTAIL);
        end
      end
      push_vc = $urandom_range(0, VC_NUM - 1);
      do_push = on_off_o[push_vc] && (!drain || rem[push_vc] > 0) && ($urandom_range(0, 3) != 0);
      if (do_push) begin
        if (rem[push_vc] == 0) begin
          len = $urandom_range(1, 5);
          pf.flit_label = (len == 1) ? HEADTAIL : HEAD;
          rem[push_vc]  = len - 1;
        end else begin
          rem[push_vc]--;
          pf.flit_label = (rem[push_vc] == 0) ? TAIL : BODY;
        end
        pf.data = PAYLOAD_W'($urandom);
        drive(pf.flit_label, VC_SIZE'(push_vc), pf.data);
      end else begin
        idle_in();
      end
      out_ready_i = rdy;
      full_pre = (mq[push_vc].size() >= DEPTH);
      if (do_pop) begin
        void'(mq[pop_vc].pop_front());
        if (pop_end) m_alloc[pop_vc] = 1'b1;
      end
      if (do_push && !full_pre) begin
        mq[push_vc].push_back(pf);
        if ((pf.flit_label == HEAD) || (pf.flit_label == HEADTAIL)) m_alloc[push_vc] = 1'b0;
      end
    end
    idle_in();
    total = 0;
    for (int v = 0; v < VC_NUM; v++) total += mq[v].size() + rem[v];
    checks++;
    if (total != 0) begin errors++; $display("FAIL rnd_drain got %0d flits left expected 0", total); end
  endtask

  initial begin
    rst_n       = 1'b0;
    out_ready_i = 1'b0;
    idle_in();
    test_reset();
    test_single_headtail();
    test_four_flit();
    test_no_interleave();
    test_rr_fairness();
    test_reset_mid_packet();
    test_error_checker();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_depacketizer.md
# noc_depacketizer

Local-port ejection interface: accepts flits from a router LOCAL output port and reassembles them into per-packet flit streams for the attached core. It keeps one FIFO per virtual channel and returns per-VC on/off flow control and VC-allocatable status to the router. It drains one complete packet at a time, so packets from different VCs never interleave on the output.

## Interface
- BUF_DEPTH, 4: flit slots per VC FIFO; must be at least 3 and a power of two.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flit_i  in  flit_t  incoming flit; `vc_id` selects the destination FIFO.
- valid_i  in  1  qualifies `flit_i`.
- on_off_o  out  VC_NUM  per-VC permission to send. Reset value all 1s.
- is_allocatable_o  out  VC_NUM  per-VC "no packet resident" flag. Reset value all 1s.
- out_flit_o  out  flit_novc_t  head flit of the granted VC, with `vc_id` stripped.
- out_vc_o  out  VC_SIZE  source VC of `out_flit_o`. Reset value 0.
- out_sop_o / out_eop_o  out  1 each  first / last flit of the packet. Reset value 0.
- out_valid_o  out  1  output flit valid. Reset value 0.
- out_ready_i  in  1  consumer accepts the flit.
- err_o  out  1  one-cycle protocol-error pulse. Reset value 0.

## Operation
- Write path:
  - When `valid_i` is high, the flit is stored in FIFO[`flit_i.vc_id`] as `flit_novc_t`.
  - Each FIFO is first-word-fall-through, with a count of width $clog2(BUF_DEPTH)+1.
- Flow control:
  - `on_off_o[v]` = (count[v] < BUF_DEPTH-1), decoded combinationally from the registered count.
  - This guarantees one slot of slack for a flit already in flight.
- Allocatable flag:
  - `is_allocatable_o[v]` clears on the cycle after a HEAD or HEADTAIL is written into VC v.
  - It sets on the cycle after that packet's TAIL or HEADTAIL is popped at the output.
- Output FSM:
  - IDLE: round-robin search starting at `rr_ptr` for a non-empty VC whose head-of-FIFO label is HEAD or HEADTAIL.
    - The search is combinational. The selected flit is presented in the same cycle with `out_sop_o`=1.
    - On handshake (`out_valid_o` && `out_ready_i`): a HEADTAIL stays in IDLE and `rr_ptr` advances to grant+1; a HEAD latches `lock_vc` and moves to STREAM.
  - STREAM: `out_valid_o` = FIFO[`lock_vc`] non-empty.
    - A TAIL drives `out_eop_o`=1. Its handshake returns the FSM to IDLE and sets `rr_ptr` = `lock_vc`+1, wrapping modulo VC_NUM.
    - HEADTAIL drives both `out_sop_o` and `out_eop_o`.
- Simultaneous push and pop on the same VC leaves the count unchanged.
- There is no bypass: a flit written into an empty FIFO becomes visible one cycle later.
- A push to a full FIFO is ignored.
- `out_flit_o` is don't-care while `out_valid_o`=0. The bench checks it only when valid.

## Timing
- Latency from the `valid_i` edge to `out_valid_o` is 1 cycle, with an empty FIFO, FSM in IDLE and no competing VC.
- Sustained throughput is 1 flit/cycle per packet. There is no bubble between a TAIL and the next HEAD on another VC.
- `on_off_o` and `is_allocatable_o` reflect state registered at the previous edge.
- Reset (asynchronous, any time, including mid-packet):
  - flushes all FIFOs and puts the FSM in IDLE;
  - sets `rr_ptr`=0 and `lock_vc`=0;
  - drives every output to the reset value listed above.
  - Partial packets are discarded.

## Configuration
- DEPKT_CHECK_EN defined: a per-VC input "open" flag is compiled in. Each of the following drops the flit (no write) and pulses `err_o` for one cycle:
  - BODY or TAIL arriving on a VC that is not open;
  - HEAD or HEADTAIL arriving on a VC that is open;
  - any write to a full FIFO.
- DEPKT_CHECK_EN undefined: all flits are written unconditionally (full writes are still ignored) and `err_o` is tied to 0.

## Structure
- Additions to the shared package `noc_params`:
  - `depkt_state_t` enum {IDLE, STREAM};
  - localparam `DEPKT_BUF_DEPTH` = 4, used as the BUF_DEPTH default.
- Sub-module `depkt_vc_fifo`: one per VC, parameterised by BUF_DEPTH. It provides push, pop, `head`, `empty`, `full` and `count` as a flit_novc_t FWFT FIFO.
- Top-level logic: round-robin arbiter, FSM, allocatable flags, and the error checker under DEPKT_CHECK_EN.

## Test plan
- **Single HEADTAIL:** VC1 HEADTAIL with head_pl=0x2A, `out_ready_i`=1.
  - Next cycle: `out_valid_o`=1, `out_sop_o`=`out_eop_o`=1, `out_vc_o`=1.
  - `is_allocatable_o` goes 2'b11 → 2'b01 → 2'b11.
- **4-flit packet on VC0:** HEAD, BODY, BODY, TAIL with `out_ready_i`=0.
  - After the 3rd flit, `on_off_o[0]`=0.
  - Raising ready drains the 4 flits on consecutive cycles, with sop on flit 1 and eop on flit 4.
- **No interleave:** VC0 HEAD arrives, then a complete VC1 HEADTAIL, then the VC0 BODY and TAIL.
  - Output order is VC0 HEAD, BODY, TAIL, then VC1 HEADTAIL.
  - `rr_ptr` ends at 0 (VC1+1, wrapped modulo 2).
- **Round-robin fairness:** both VCs hold a ready HEADTAIL at the same time.
  - Grants alternate 0, 1, 0, 1 over 4 packets.
- **Reset mid-packet:** `rst_n` drops after VC0 HEAD+BODY.
  - All outputs take reset values immediately; `on_off_o`=2'b11.
  - A new VC0 HEADTAIL after reset emerges normally.
- **Error checker (DEPKT_CHECK_EN):** BODY sent on an idle VC1.
  - `err_o` pulses for 1 cycle, FIFO[1] count stays 0, and no output appears.
  - With the macro undefined, `err_o` stays 0.
